updown_counter_param: RTL

Parametrised up/down counter with a programmable modulus, synchronous load, count enable, an optional clock-enable prescaler and a wrap-or-saturate mode. It is the next-generation replacement for the fixed 4-bit up/down counter. It serves as the general event/timer counter in the design, providing terminal-count and wrap flags for downstream sequencing logic.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_prescaler.sv | 61 ++++++
 rtl/updown_counter_param.sv | 113 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the parametrised up/down counter.
//   DIR_UP / DIR_DOWN : encoding of the up_down input.
//   phase_width()     : bit width for a prescaler phase counter of a given
//                       modulus. It never returns less than 1.
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Width for a phase counter that covers 0..prescale-1.
    function automatic int unsigned phase_width(input int unsigned prescale);
        int unsigned w;
        w = (prescale > 1) ? $clog2(prescale) : 1;
        return w;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
// Clock-enable divider. It produces a one-cycle tick once per PRESCALE cycles
// in which en is high. The phase holds while en is low, so a paused count
// resumes without losing its position.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset; phase returns to 0
//   en     in   advance the phase this cycle
//   clear  in   synchronous phase clear; takes priority over en
//   tick   out  high when en is high and the phase is at PRESCALE-1
// -----------------------------------------------------------------------------
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    if (PRESCALE <= 1) begin : g_bypass
        // Every enabled cycle is a tick, so no state is needed.
        logic unused_inputs;
        assign unused_inputs = ^{clk, reset, clear};
        assign tick          = en;
    end else begin : g_divide
        localparam int unsigned PhaseW = phase_width(PRESCALE);
        localparam logic [PhaseW-1:0] LastPhase = PhaseW'(PRESCALE - 1);
        localparam logic [PhaseW-1:0] PhaseOne  = PhaseW'(1);

        logic [PhaseW-1:0] phase_q;
        logic [PhaseW-1:0] phase_d;
        logic              at_last;

        assign at_last = (phase_q == LastPhase);
        assign tick    = en & at_last;

        always_comb begin
            phase_d = phase_q;
            if (clear) begin
                phase_d = '0;
            end else if (en) begin
                phase_d = at_last ? '0 : (phase_q + PhaseOne);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_d;
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
// Parametrised up/down counter over the range 0..MAX_VALUE. It supports a
// synchronous clamped load, a count enable, an optional prescaler, and either
// wrap or saturate behaviour at the range ends.
//
// Parameters:
//   WIDTH      counter width in bits (>= 2)
//   MAX_VALUE  top of the count range (1 .. 2**WIDTH-1)
//   PRESCALE   enabled cycles per count step (>= 1)
//   SATURATE   0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   en          in   count enable; counter and prescaler hold while low
//   up_down     in   1 = count up, 0 = count down
//   load        in   synchronous load; overrides counting
//   load_value  in   load data, clamped to MAX_VALUE
//   count       out  registered count
//   tc          out  terminal count: this cycle's step hits a range end
//   wrapped     out  registered one-cycle pulse after a wrap
// -----------------------------------------------------------------------------
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_VALUE = 2 ** WIDTH - 1,
    parameter int unsigned PRESCALE  = 1,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrapped_q;
    logic             wrapped_d;

    logic             tick;
    logic             step;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;

    // A load restarts the prescaler so the next step is a full period away.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (load),
        .tick  (tick)
    );

    assign step    = en & tick;
    assign at_max  = (count_q == MaxVal);
    assign at_zero = (count_q == '0);

    assign load_clamped = (load_value > MaxVal) ? MaxVal : load_value;

    // tc ignores load: it flags the boundary step even if a load pre-empts it.
    assign tc = step & (((up_down == DIR_UP) & at_max) |
                        ((up_down == DIR_DOWN) & at_zero));

    always_comb begin
        count_d   = count_q;
        wrapped_d = tc & (SATURATE == 1'b0) & ~load;
        if (load) begin
            count_d = load_clamped;
        end else if (step) begin
            if (up_down == DIR_UP) begin
                if (at_max) begin
                    count_d = SATURATE ? count_q : '0;
                end else begin
                    count_d = count_q + CountOne;
                end
            end else begin
                if (at_zero) begin
                    count_d = SATURATE ? count_q : MaxVal;
                end else begin
                    count_d = count_q - CountOne;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;

endmodule
